// File: rtl/mem2_pkg.sv
// Shared types and constants for the second-slot memory stage.
package mem2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // MemtoReg write-back source select
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC2 = 2'b10;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic [7:0]  pc_plus2;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  dest_reg;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic        is_store;
  } hold_t;

endpackage

// File: rtl/mem2_timeout_ctr.sv
// WAIT-cycle counter: the first counted cycle reads 1, expired flags the TIMEOUT-th.
module mem2_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= 8'd0;
    end else if (enable) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = (count_reg == 8'(TIMEOUT));

endmodule

// File: rtl/mem_stage_inst2.sv
// MEM stage for issue slot 2: ALU ops pass through, loads/stores run a req/ack handshake.
// Optional alignment trap enabled by defining MEM2_MISALIGN_CHECK_EN.
module mem_stage_inst2
  import mem2_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_inst2_Ex,
  input  logic [7:0]  pcPlus2_Ex,
  input  logic [31:0] AluResultEx_inst2,
  input  logic [31:0] WriteDataEx_inst2,
  input  logic [4:0]  dest_reg_inst2_Ex,
  input  logic [1:0]  MemtoRegEx_inst2,
  input  logic        RegWriteEn_inst2_Ex,
  input  logic        MemReadEn_inst2_Ex,
  input  logic        MemWriteEn_inst2_Ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [7:0]  pcPlus2_Mem,
  output logic [31:0] MemReadDataMem_inst2,
  output logic [31:0] AluResultMem_inst2,
  output logic [4:0]  dest_reg_inst2_Mem,
  output logic [1:0]  MemtoRegMem_inst2,
  output logic        RegWriteEn_inst2_Mem,
  output logic        stall_inst2,
  output logic        bus_err_inst2,
  output logic        misalign_inst2
);

  state_t      state_reg;
  hold_t       hold_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        misalign_hit;
  logic        mem_op;
  logic        start;
  logic        to_wait;
  logic        expired;
  logic        drop_write;

  assign mem_op  = MemReadEn_inst2_Ex || MemWriteEn_inst2_Ex;
  assign start   = (state_reg == IDLE) && valid_inst2_Ex && mem_op;
  // Counter runs exactly while the next state is WAIT, so the first WAIT cycle reads 1.
  assign to_wait = (start && !misalign_hit) ||
                   ((state_reg == WAIT) && !dmem_ack && !expired);

  mem2_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!to_wait),
    .enable  (to_wait),
    .expired (expired)
  );

`ifdef MEM2_MISALIGN_CHECK_EN
  logic misalign_reg;

  assign misalign_hit   = (AluResultEx_inst2[1:0] != 2'b00);
  assign misalign_inst2 = (state_reg == DONE) && misalign_reg;
  assign drop_write     = err_reg || misalign_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      misalign_reg <= 1'b0;
    end else if (start) begin
      misalign_reg <= misalign_hit;
    end
  end
`else
  assign misalign_hit   = 1'b0;
  assign misalign_inst2 = 1'b0;
  assign drop_write     = err_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            hold_reg.pc_plus2   <= pcPlus2_Ex;
            hold_reg.alu_result <= AluResultEx_inst2;
            hold_reg.write_data <= WriteDataEx_inst2;
            hold_reg.dest_reg   <= dest_reg_inst2_Ex;
            hold_reg.mem_to_reg <= MemtoRegEx_inst2;
            hold_reg.reg_write  <= RegWriteEn_inst2_Ex;
            hold_reg.is_store   <= MemWriteEn_inst2_Ex;
            rdata_reg           <= 32'h0;
            err_reg             <= 1'b0;
            state_reg           <= misalign_hit ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            // Stores leave the read-data register at zero.
            rdata_reg <= hold_reg.is_store ? 32'h0 : dmem_rdata;
            state_reg <= DONE;
          end else if (expired) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    dmem_req             = 1'b0;
    dmem_we              = 1'b0;
    dmem_addr            = 32'h0;
    dmem_wdata           = 32'h0;
    pcPlus2_Mem          = 8'h0;
    MemReadDataMem_inst2 = 32'h0;
    AluResultMem_inst2   = 32'h0;
    dest_reg_inst2_Mem   = 5'd0;
    MemtoRegMem_inst2    = 2'b00;
    RegWriteEn_inst2_Mem = 1'b0;
    stall_inst2          = 1'b0;
    bus_err_inst2        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_inst2_Ex) begin
          if (mem_op) begin
            stall_inst2 = 1'b1;
          end else begin
            pcPlus2_Mem          = pcPlus2_Ex;
            AluResultMem_inst2   = AluResultEx_inst2;
            dest_reg_inst2_Mem   = dest_reg_inst2_Ex;
            MemtoRegMem_inst2    = MemtoRegEx_inst2;
            RegWriteEn_inst2_Mem = RegWriteEn_inst2_Ex;
          end
        end
      end
      WAIT: begin
        stall_inst2 = 1'b1;
        dmem_req    = 1'b1;
        dmem_we     = hold_reg.is_store;
        dmem_addr   = hold_reg.alu_result;
        dmem_wdata  = hold_reg.write_data;
      end
      DONE: begin
        pcPlus2_Mem          = hold_reg.pc_plus2;
        MemReadDataMem_inst2 = rdata_reg;
        AluResultMem_inst2   = hold_reg.alu_result;
        dest_reg_inst2_Mem   = hold_reg.dest_reg;
        MemtoRegMem_inst2    = hold_reg.mem_to_reg;
        RegWriteEn_inst2_Mem = hold_reg.reg_write && !drop_write;
        bus_err_inst2        = err_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_inst2.sv
// Randomized bench for mem_stage_inst2 with a per-transaction timeline model.
module tb_mem_stage_inst2;
  import mem2_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_inst2_Ex;
  logic [7:0]  pcPlus2_Ex;
  logic [31:0] AluResultEx_inst2;
  logic [31:0] WriteDataEx_inst2;
  logic [4:0]  dest_reg_inst2_Ex;
  logic [1:0]  MemtoRegEx_inst2;
  logic        RegWriteEn_inst2_Ex;
  logic        MemReadEn_inst2_Ex;
  logic        MemWriteEn_inst2_Ex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [7:0]  pcPlus2_Mem;
  logic [31:0] MemReadDataMem_inst2;
  logic [31:0] AluResultMem_inst2;
  logic [4:0]  dest_reg_inst2_Mem;
  logic [1:0]  MemtoRegMem_inst2;
  logic        RegWriteEn_inst2_Mem;
  logic        stall_inst2;
  logic        bus_err_inst2;
  logic        misalign_inst2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_inst2 #(.TIMEOUT(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .valid_inst2_Ex       (valid_inst2_Ex),
    .pcPlus2_Ex           (pcPlus2_Ex),
    .AluResultEx_inst2    (AluResultEx_inst2),
    .WriteDataEx_inst2    (WriteDataEx_inst2),
    .dest_reg_inst2_Ex    (dest_reg_inst2_Ex),
    .MemtoRegEx_inst2     (MemtoRegEx_inst2),
    .RegWriteEn_inst2_Ex  (RegWriteEn_inst2_Ex),
    .MemReadEn_inst2_Ex   (MemReadEn_inst2_Ex),
    .MemWriteEn_inst2_Ex  (MemWriteEn_inst2_Ex),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_ack             (dmem_ack),
    .dmem_rdata           (dmem_rdata),
    .pcPlus2_Mem          (pcPlus2_Mem),
    .MemReadDataMem_inst2 (MemReadDataMem_inst2),
    .AluResultMem_inst2   (AluResultMem_inst2),
    .dest_reg_inst2_Mem   (dest_reg_inst2_Mem),
    .MemtoRegMem_inst2    (MemtoRegMem_inst2),
    .RegWriteEn_inst2_Mem (RegWriteEn_inst2_Mem),
    .stall_inst2          (stall_inst2),
    .bus_err_inst2        (bus_err_inst2),
    .misalign_inst2       (misalign_inst2)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [1:0]  m2r;
    logic        rw;
    logic        stall;
    logic        berr;
    logic        mis;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obs_t;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp(input string ph, input obs_t e);
    check_val({ph, ".pc"},    32'(pcPlus2_Mem),          32'(e.pc));
    check_val({ph, ".rdata"}, MemReadDataMem_inst2,      e.rd);
    check_val({ph, ".alu"},   AluResultMem_inst2,        e.alu);
    check_val({ph, ".dest"},  32'(dest_reg_inst2_Mem),   32'(e.dest));
    check_val({ph, ".m2r"},   32'(MemtoRegMem_inst2),    32'(e.m2r));
    check_val({ph, ".rw"},    32'(RegWriteEn_inst2_Mem), 32'(e.rw));
    check_val({ph, ".stall"}, 32'(stall_inst2),          32'(e.stall));
    check_val({ph, ".berr"},  32'(bus_err_inst2),        32'(e.berr));
    check_val({ph, ".mis"},   32'(misalign_inst2),       32'(e.mis));
    check_val({ph, ".req"},   32'(dmem_req),             32'(e.req));
    check_val({ph, ".we"},    32'(dmem_we),              32'(e.we));
    check_val({ph, ".addr"},  dmem_addr,                 e.addr);
    check_val({ph, ".wdata"}, dmem_wdata,                e.wdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [7:0] pc, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] dest, input logic [1:0] m2r,
                          input logic rw, input logic rd_en, input logic wr_en);
    valid_inst2_Ex      = v;
    pcPlus2_Ex          = pc;
    AluResultEx_inst2   = alu;
    WriteDataEx_inst2   = wd;
    dest_reg_inst2_Ex   = dest;
    MemtoRegEx_inst2    = m2r;
    RegWriteEn_inst2_Ex = rw;
    MemReadEn_inst2_Ex  = rd_en;
    MemWriteEn_inst2_Ex = wr_en;
  endtask

  task automatic scramble_ex();
    drive_ex(1'($urandom), 8'($urandom), $urandom, $urandom, 5'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Non-memory instruction: visible on the MEM side in the same cycle.
  task automatic alu_op(input logic [7:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                        input logic [1:0] m2r, input logic rw);
    obs_t e;
    drive_ex(1'b1, pc, alu, $urandom, dest, m2r, rw, 1'b0, 1'b0);
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    e = '0;
    e.pc = pc; e.alu = alu; e.dest = dest; e.m2r = m2r; e.rw = rw;
    @(negedge clk);
    cmp("alu", e);
    $display("alu   pc=%h alu=%h dest=%0d rw=%b", pc, alu, dest, rw);
    step();
  endtask

  task automatic bubble();
    drive_ex(1'b0, 8'($urandom), $urandom, $urandom, 5'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    cmp("bubble", '0);
    $display("idle  valid=0");
    step();
  endtask

  // Load/store: capture cycle, WAIT until ack (ack_at, 1-based) or TIMEOUT, then one DONE cycle.
  task automatic mem_op(input logic st, input logic both, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [7:0] pc, input logic [4:0] dest,
                        input logic [1:0] m2r, input logic rw, input int ack_at,
                        input logic [31:0] rdata);
    obs_t e;
    logic acked;
    logic mis;
    int   waits;
    drive_ex(1'b1, pc, addr, wd, dest, m2r, rw, st ? both : 1'b1, st);
    dmem_ack = 1'b0;
    e = '0;
    e.stall = 1'b1;
    @(negedge clk);
    cmp("cap", e);
    step();
    mis = 1'b0;
`ifdef MEM2_MISALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`endif
    acked = 1'b0;
    waits = 0;
    if (!mis) begin
      for (int i = 1; i <= TO; i++) begin
        dmem_ack   = (i == ack_at);
        dmem_rdata = (i == ack_at) ? rdata : $urandom;
        e = '0;
        e.stall = 1'b1; e.req = 1'b1; e.we = st; e.addr = addr; e.wdata = wd;
        @(negedge clk);
        cmp("wait", e);
        waits++;
        step();
        if (i == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
    end
    scramble_ex();
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    e = '0;
    e.pc = pc; e.alu = addr; e.dest = dest; e.m2r = m2r;
    e.rd   = (acked && !st) ? rdata : 32'h0;
    e.rw   = rw && acked;
    e.berr = !acked && !mis;
    e.mis  = mis;
    @(negedge clk);
    cmp("done", e);
    $display("%s pc=%h addr=%h waits=%0d acked=%b mis=%b", st ? "store" : "load ",
             pc, addr, waits, acked, mis);
    step();
    dmem_ack = 1'b0;
  endtask

  initial begin
    obs_t e;
    int   kind;
    logic [31:0] a;
    reset = 1'b1;
    drive_ex(1'b0, 8'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    step();
    step();
    @(negedge clk);
    cmp("reset", '0);
    $display("reset applied");
    reset    = 1'b0;
    dmem_ack = 1'b0;
    step();

    alu_op(8'h10, 32'h0000_1234, 5'd5, MEMTOREG_ALU, 1'b1);
    mem_op(1'b0, 1'b0, 32'h40, 32'h0, 8'h12, 5'd7, MEMTOREG_MEM, 1'b1, 2, 32'hCAFE_F00D);
    mem_op(1'b1, 1'b0, 32'h80, 32'hA5A5_A5A5, 8'h14, 5'd0, MEMTOREG_ALU, 1'b0, 1, 32'h0);
    mem_op(1'b0, 1'b0, 32'h100, 32'h0, 8'h16, 5'd9, MEMTOREG_MEM, 1'b1, TO + 1, 32'hDEAD_BEEF);
    alu_op(8'h18, 32'hFFFF_0000, 5'd31, MEMTOREG_PC2, 1'b1);

    // Reset while a load is waiting, then a stray ack arrives.
    drive_ex(1'b1, 8'h30, 32'h200, 32'h5, 5'd4, MEMTOREG_MEM, 1'b1, 1'b1, 1'b0);
    dmem_ack = 1'b0;
    e = '0;
    e.stall = 1'b1;
    @(negedge clk);
    cmp("rst_cap", e);
    step();
    e.req = 1'b1; e.addr = 32'h200; e.wdata = 32'h5;
    @(negedge clk);
    cmp("rst_wait", e);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_ex(1'b0, 8'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    cmp("rst_idle", '0);
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    cmp("rst_idle2", '0);
    $display("reset during WAIT, late ack ignored");
    step();

    mem_op(1'b0, 1'b0, 32'h42, 32'h0, 8'h20, 5'd3, MEMTOREG_MEM, 1'b1, 1, 32'h1122_3344);
    mem_op(1'b1, 1'b1, 32'hC0, 32'h0F0F_0F0F, 8'h22, 5'd0, MEMTOREG_ALU, 1'b0, 3, 32'h0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      case (kind)
        0: bubble();
        1: alu_op(8'($urandom), a, 5'($urandom), 2'($urandom_range(0, 2)), 1'($urandom));
        2: mem_op(1'b0, 1'b0, a, $urandom, 8'($urandom), 5'($urandom), MEMTOREG_MEM,
                  1'($urandom), int'($urandom_range(1, TO + 2)), $urandom);
        default: mem_op(1'b1, 1'($urandom), a, $urandom, 8'($urandom), 5'($urandom),
                        MEMTOREG_ALU, 1'b0, int'($urandom_range(1, TO + 2)), $urandom);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
